pwm_demodulator: RTL and testbench

- Receive-side counterpart of the AM PWM modulator. Recovers one BITS_PER_SAMPLE-bit sample per PWM frame by counting PWM steps where the line is high.
- Takes the modulator's pwm and nsync lines, resynchronises them and measures duty per step.
- Pushes each recovered sample into a downstream FIFO through a write/full interface.
- Used for loopback checking of the TX chain and as the RX front end on the board.

---
 rtl/pwm_demodulator.sv | 187 ++++++++++++++++++
 tb/tb_pwm_demodulator.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demodulator.sv
// pwm_demodulator: recovers one BITS_PER_SAMPLE-bit sample per PWM frame by counting mid-step highs.
// Optional DEMOD_RESYNC_EN: mid-frame nsync falling edges realign the frame and pulse resync_err.
module pwm_demodulator #(
  parameter int CLKS_PER_PWM_STEP   = 1000,
  parameter int PWM_STEP_PER_SAMPLE = 255,
  parameter int BITS_PER_SAMPLE     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       pwm,
  input  logic                       nsync,
  input  logic                       full,
  output logic [BITS_PER_SAMPLE-1:0] sample,
  output logic                       write,
  output logic                       overflow,
  output logic                       locked
`ifdef DEMOD_RESYNC_EN
  ,
  output logic                       resync_err
`endif
);

  localparam int CW = (CLKS_PER_PWM_STEP > 1) ? $clog2(CLKS_PER_PWM_STEP) : 1;
  localparam int SW = $clog2(PWM_STEP_PER_SAMPLE + 1);
  localparam int HW = $clog2(PWM_STEP_PER_SAMPLE + 1);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_PWM_STEP - 1);
  localparam logic [CW-1:0] CLK_MID   = CW'(CLKS_PER_PWM_STEP / 2);
  localparam logic [SW-1:0] STEP_LAST = SW'(PWM_STEP_PER_SAMPLE - 1);
  localparam logic [BITS_PER_SAMPLE-1:0] SAMPLE_MAX = '1;

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  state_t                     state, state_n;
  logic [CW-1:0]              clk_cnt, clk_n;
  logic [SW-1:0]              step_cnt, step_n;
  logic [HW-1:0]              hi_cnt, hi_n, final_val;
  logic                       pwm_m, pwm_s, nsync_m, nsync_s;
  logic                       mid_hi, end_step, eof, abort;
  logic [BITS_PER_SAMPLE-1:0] sample_sat;

  // Two-flop synchronisers for the asynchronous modulator lines.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_m   <= 1'b0;
      pwm_s   <= 1'b0;
      nsync_m <= 1'b1;
      nsync_s <= 1'b1;
    end else begin
      pwm_m   <= pwm;
      pwm_s   <= pwm_m;
      nsync_m <= nsync;
      nsync_s <= nsync_m;
    end
  end

  assign mid_hi    = (state == MEASURE) && (clk_cnt == CLK_MID) && pwm_s;
  assign end_step  = (state == MEASURE) && (clk_cnt == CLK_LAST);
  assign eof       = end_step && (step_cnt == STEP_LAST);
  // Covers CLKS_PER_PWM_STEP=2, where the mid sample lands on the last clock of the step.
  assign final_val = hi_cnt + HW'(mid_hi);

`ifdef DEMOD_RESYNC_EN
  logic nsync_d;
  logic nsync_fall;

  // Previous synchronised nsync for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      nsync_d <= 1'b1;
    end else begin
      nsync_d <= nsync_s;
    end
  end

  assign nsync_fall = nsync_d & ~nsync_s;
  // An edge seen on the frame's last clock puts the next cycle at step 0 / clock 0: aligned.
  assign abort = (state == MEASURE) && nsync_fall && !eof;

  // One-clock pulse per resync abort.
  always_ff @(posedge clk) begin
    if (!rst) begin
      resync_err <= 1'b0;
    end else begin
      resync_err <= abort;
    end
  end
`else
  assign abort = 1'b0;
`endif

  // Saturate the recovered count to the sample width.
  always_comb begin
    sample_sat = '0;
    if (64'(final_val) > 64'(SAMPLE_MAX)) begin
      sample_sat = SAMPLE_MAX;
    end else begin
      sample_sat = BITS_PER_SAMPLE'(final_val);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      step_cnt <= '0;
      hi_cnt   <= '0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_n;
      step_cnt <= step_n;
      hi_cnt   <= hi_n;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_n = state;
    clk_n   = clk_cnt;
    step_n  = step_cnt;
    hi_n    = hi_cnt;
    case (state)
      IDLE: begin
        clk_n  = '0;
        step_n = '0;
        hi_n   = '0;
        if (enable && !nsync_s) begin
          state_n = MEASURE;
        end else begin
          state_n = IDLE;
        end
      end
      MEASURE: begin
        if (!enable || abort) begin
          clk_n  = '0;
          step_n = '0;
          hi_n   = '0;
          if (!enable) begin
            state_n = IDLE;
          end else begin
            state_n = MEASURE;
          end
        end else if (eof) begin
          clk_n  = '0;
          step_n = '0;
          hi_n   = '0;
        end else if (end_step) begin
          clk_n  = '0;
          step_n = step_cnt + SW'(1);
          hi_n   = final_val;
        end else begin
          clk_n  = clk_cnt + CW'(1);
          hi_n   = final_val;
        end
      end
      default: begin
        state_n = IDLE;
        clk_n   = '0;
        step_n  = '0;
        hi_n    = '0;
      end
    endcase
  end

  // Registered outputs and FIFO write handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample   <= '0;
      write    <= 1'b0;
      overflow <= 1'b0;
      locked   <= 1'b0;
    end else begin
      locked <= (state_n == MEASURE);
      write  <= 1'b0;
      if (eof && !abort) begin
        sample <= sample_sat;
        if (full) begin
          overflow <= 1'b1;
        end else begin
          write <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_demodulator.sv
// Self-checking bench for pwm_demodulator: a behavioural modulator drives frames and a
// step-count model predicts every write (value and cycle). DEMOD_RESYNC_EN adds resync tests.
module tb_pwm_demodulator;
  localparam int CPS     = 4;
  localparam int PSS     = 255;
  localparam int BPS     = 8;
  localparam int N       = CPS * PSS;
  localparam int PSS_SAT = 300;
  localparam int N_SAT   = CPS * PSS_SAT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic pwm = 1'b0;
  logic nsync = 1'b1;
  logic full = 1'b0;
  logic [BPS-1:0] sample, sample_sat;
  logic write, overflow, locked;
  logic write_sat, overflow_sat, locked_sat;
`ifdef DEMOD_RESYNC_EN
  logic resync_err, resync_err_sat;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int resync_cnt = 0;
  int wr_cyc[$];
  int wr_val[$];
  int sat_cyc[$];
  int sat_val[$];

  pwm_demodulator #(.CLKS_PER_PWM_STEP(CPS), .PWM_STEP_PER_SAMPLE(PSS), .BITS_PER_SAMPLE(BPS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pwm(pwm), .nsync(nsync), .full(full),
    .sample(sample), .write(write), .overflow(overflow), .locked(locked)
`ifdef DEMOD_RESYNC_EN
    , .resync_err(resync_err)
`endif
  );

  pwm_demodulator #(.CLKS_PER_PWM_STEP(CPS), .PWM_STEP_PER_SAMPLE(PSS_SAT), .BITS_PER_SAMPLE(BPS)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .pwm(pwm), .nsync(nsync), .full(1'b0),
    .sample(sample_sat), .write(write_sat), .overflow(overflow_sat), .locked(locked_sat)
`ifdef DEMOD_RESYNC_EN
    , .resync_err(resync_err_sat)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observed write events, logged mid-cycle.
  always @(negedge clk) begin
    if (write) begin
      wr_cyc.push_back(cyc);
      wr_val.push_back(int'(sample));
    end
    if (write_sat) begin
      sat_cyc.push_back(cyc);
      sat_val.push_back(int'(sample_sat));
    end
`ifdef DEMOD_RESYNC_EN
    if (resync_err) resync_cnt++;
`endif
  end

  // Reference: the sample is the number of high steps, saturated to the sample width.
  function automatic int model_sample(input int value, input int steps);
    int hi;
    hi = (value < steps) ? value : steps;
    return (hi > (1 << BPS) - 1) ? (1 << BPS) - 1 : hi;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_val.delete();
    sat_cyc.delete();
    sat_val.delete();
    resync_cnt = 0;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
  endtask

  // Modulator model: nsync low on the first clock; step s is high when s < value.
  task automatic send_frame(input int value, input int steps);
    for (int s = 0; s < steps; s++) begin
      for (int k = 0; k < CPS; k++) begin
        nsync = (s == 0 && k == 0) ? 1'b0 : 1'b1;
        pwm   = (s < value) ? 1'b1 : 1'b0;
        tick(1);
      end
    end
    nsync = 1'b1;
    pwm   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b0;
    tick(3);
    @(negedge clk);
    n_checks++;
    if (sample !== 8'h00) begin n_fail++; $display("FAIL reset_sample: got %0h expected 0", sample); end
    n_checks++;
    if (write !== 1'b0 || overflow !== 1'b0 || locked !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got w=%b o=%b l=%b expected 0 0 0", write, overflow, locked);
    end
`ifdef DEMOD_RESYNC_EN
    n_checks++;
    if (resync_err !== 1'b0) begin n_fail++; $display("FAIL reset_resync_err: got %b expected 0", resync_err); end
`endif
    rst = 1'b1;
    enable = 1'b1;
    tick(3);
    @(negedge clk);
    n_checks++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL idle_locked: got %b expected 0", locked); end
    tick(1);
  endtask

  task automatic test_loopback();
    int vals[$];
    int c0, n;
    vals = '{3, 5, 0, 15, 2, 255};
    repeat (3) vals.push_back(int'($urandom_range(0, 255)));
    clear_log();
    c0 = cyc;
    foreach (vals[i]) send_frame(vals[i], PSS);
    tick(8);
    n_checks++;
    if (wr_val.size() !== vals.size()) begin
      n_fail++; $display("FAIL loopback_count: got %0d expected %0d", wr_val.size(), vals.size());
    end
    n = (wr_val.size() < vals.size()) ? wr_val.size() : vals.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (wr_val[i] !== model_sample(vals[i], PSS)) begin
        n_fail++; $display("FAIL loopback_val[%0d]: got %0d expected %0d", i, wr_val[i], model_sample(vals[i], PSS));
      end
      n_checks++;
      if (wr_cyc[i] !== c0 + 3 + (i + 1) * N) begin
        n_fail++; $display("FAIL loopback_time[%0d]: got %0d expected %0d", i, wr_cyc[i], c0 + 3 + (i + 1) * N);
      end
    end
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL loopback_overflow: got %b expected 0", overflow); end
    n_checks++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL loopback_locked: got %b expected 1", locked); end
    tick(1);
  endtask

  task automatic test_overflow();
    int c0;
    go_idle();
    clear_log();
    c0 = cyc;
    fork
      begin
        send_frame(5, PSS);
        send_frame(0, PSS);
      end
      begin
        tick(N + 1);
        full = 1'b1;
        tick(4);
        full = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sample !== 8'h05) begin n_fail++; $display("FAIL overflow_sample_held: got %0h expected 05", sample); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", overflow); end
      end
    join
    tick(8);
    n_checks++;
    if (wr_val.size() !== 1) begin
      n_fail++; $display("FAIL overflow_count: got %0d expected 1", wr_val.size());
    end else begin
      n_checks++;
      if (wr_val[0] !== 0 || wr_cyc[0] !== c0 + 3 + 2 * N) begin
        n_fail++; $display("FAIL overflow_next_write: got val %0d at %0d expected 0 at %0d", wr_val[0], wr_cyc[0], c0 + 3 + 2 * N);
      end
    end
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
    tick(1);
  endtask

  task automatic test_enable_abort();
    int c0, va, vb;
    va = int'($urandom_range(0, 255));
    vb = int'($urandom_range(1, 254));
    go_idle();
    clear_log();
    c0 = cyc;
    fork
      begin
        send_frame(va, PSS);
        send_frame(vb, PSS);
      end
      begin
        tick(3 + 50 * CPS);
        enable = 1'b0;
        tick(1);
        @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL abort_locked: got %b expected 0", locked); end
        tick(8);
        enable = 1'b1;
      end
    join
    tick(8);
    n_checks++;
    if (wr_val.size() !== 1) begin
      n_fail++; $display("FAIL abort_count: got %0d expected 1", wr_val.size());
    end else begin
      n_checks++;
      if (wr_val[0] !== vb || wr_cyc[0] !== c0 + 3 + 2 * N) begin
        n_fail++; $display("FAIL abort_next_frame: got val %0d at %0d expected %0d at %0d", wr_val[0], wr_cyc[0], vb, c0 + 3 + 2 * N);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    go_idle();
    clear_log();
    c0 = cyc;
    fork
      send_frame(int'($urandom_range(1, 255)), PSS);
      begin
        tick(3 + 50 * CPS);
        rst = 1'b0;
        tick(1);
        @(negedge clk);
        n_checks++;
        if (sample !== 8'h00 || write !== 1'b0 || overflow !== 1'b0 || locked !== 1'b0) begin
          n_fail++; $display("FAIL reset_mid_outputs: got s=%0h w=%b o=%b l=%b expected all 0", sample, write, overflow, locked);
        end
        rst = 1'b1;
      end
    join
    tick(12);
    n_checks++;
    if (wr_val.size() !== 0) begin n_fail++; $display("FAIL reset_mid_write: got %0d writes expected 0", wr_val.size()); end
  endtask

  task automatic test_saturation();
    int vals[2];
    int c0;
    vals[0] = PSS_SAT;
    vals[1] = int'($urandom_range(0, PSS_SAT));
    go_idle();
    clear_log();
    c0 = cyc;
    foreach (vals[i]) send_frame(vals[i], PSS_SAT);
    tick(8);
    n_checks++;
    if (sat_val.size() !== 2) begin
      n_fail++; $display("FAIL sat_count: got %0d expected 2", sat_val.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (sat_val[i] !== model_sample(vals[i], PSS_SAT) || sat_cyc[i] !== c0 + 3 + (i + 1) * N_SAT) begin
          n_fail++; $display("FAIL sat_write[%0d]: got val %0d at %0d expected %0d at %0d", i, sat_val[i], sat_cyc[i],
                             model_sample(vals[i], PSS_SAT), c0 + 3 + (i + 1) * N_SAT);
        end
      end
    end
  endtask

`ifdef DEMOD_RESYNC_EN
  task automatic test_resync_aligned();
    int vals[3];
    go_idle();
    clear_log();
    foreach (vals[i]) vals[i] = int'($urandom_range(0, 255));
    foreach (vals[i]) send_frame(vals[i], PSS);
    tick(8);
    n_checks++;
    if (resync_cnt !== 0) begin n_fail++; $display("FAIL resync_aligned_err: got %0d pulses expected 0", resync_cnt); end
    n_checks++;
    if (wr_val.size() !== 3) begin
      n_fail++; $display("FAIL resync_aligned_count: got %0d expected 3", wr_val.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (wr_val[i] !== vals[i]) begin n_fail++; $display("FAIL resync_aligned_val[%0d]: got %0d expected %0d", i, wr_val[i], vals[i]); end
      end
    end
  endtask

  task automatic test_resync_abort();
    int xb, vb;
    vb = int'($urandom_range(0, 255));
    go_idle();
    clear_log();
    send_frame(int'($urandom_range(0, 255)), 100);
    xb = cyc;
    send_frame(vb, PSS);
    tick(8);
    n_checks++;
    if (resync_cnt !== 1) begin n_fail++; $display("FAIL resync_abort_err: got %0d pulses expected 1", resync_cnt); end
    n_checks++;
    if (wr_val.size() !== 1) begin
      n_fail++; $display("FAIL resync_abort_count: got %0d expected 1", wr_val.size());
    end else begin
      n_checks++;
      if (wr_val[0] !== vb || wr_cyc[0] !== xb + 3 + N) begin
        n_fail++; $display("FAIL resync_abort_next: got val %0d at %0d expected %0d at %0d", wr_val[0], wr_cyc[0], vb, xb + 3 + N);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_overflow();
    test_enable_abort();
    test_reset_mid();
    test_saturation();
`ifdef DEMOD_RESYNC_EN
    test_resync_aligned();
    test_resync_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
